// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry holding registers share one register
// file write port, with a pending-write scoreboard for hazard queries.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_rd_data,
    input  logic        claim_valid,
    input  logic [4:0]  claim_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        idle
);

    logic        a_full;
    logic [4:0]  a_rd_q;
    logic [31:0] a_data_q;
    logic        b_full;
    logic [4:0]  b_rd_q;
    logic [31:0] b_data_q;
    logic        last_b;
    logic        grant_a;
    logic        grant_b;
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // last_b set means B won last, so A takes the next conflict
    assign grant_a = a_full && (!b_full || last_b);
    assign grant_b = b_full && (!a_full || !last_b);

    assign a_ready = !a_full || grant_a;
    assign b_ready = !b_full || grant_b;

    always_comb begin
        rf_we      = 1'b0;
        rf_rd      = 5'd0;
        rf_rd_data = 32'd0;
        unique case (1'b1)
            grant_a: begin
                rf_we      = 1'b1;
                rf_rd      = a_rd_q;
                rf_rd_data = a_data_q;
            end
            grant_b: begin
                rf_we      = 1'b1;
                rf_rd      = b_rd_q;
                rf_rd_data = b_data_q;
            end
            default: ;
        endcase
    end

    // claim applied after clear so a same-edge claim wins
    always_comb begin
        busy_d = busy_q;
        if (rf_we)
            busy_d[rf_rd] = 1'b0;
        if (claim_valid)
            busy_d[claim_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_full   <= 1'b0;
            a_rd_q   <= 5'd0;
            a_data_q <= 32'd0;
            b_full   <= 1'b0;
            b_rd_q   <= 5'd0;
            b_data_q <= 32'd0;
            last_b   <= 1'b1;
            busy_q   <= 32'd0;
        end else begin
            busy_q <= busy_d;
            if (grant_a)
                last_b <= 1'b0;
            else if (grant_b)
                last_b <= 1'b1;
            if (a_valid && a_ready) begin
                a_full   <= (a_rd != 5'd0);
                a_rd_q   <= a_rd;
                a_data_q <= a_data;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end
            if (b_valid && b_ready) begin
                b_full   <= (b_rd != 5'd0);
                b_rd_q   <= b_rd;
                b_data_q <= b_data;
            end else if (grant_b) begin
                b_full <= 1'b0;
            end
        end
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign idle     = !a_full && !b_full && (busy_q == 32'd0);

endmodule
